// File: rtl/fifo_drain_pkg.sv
// Shared widths, state encoding and level helper for the show-ahead FIFO drainer.
package fifo_drain_pkg;

  localparam int unsigned DATA_W  = 12;
  localparam int unsigned USEDW_W = 7;
  localparam int unsigned LEVEL_W = USEDW_W + 1;

  // usedw wraps to 0 when the FIFO holds 128 words; full stands in for that level
  localparam logic [LEVEL_W-1:0] LEVEL_FULL = 8'd128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GATHER,
    ST_DRAIN
  } drain_state_e;

  function automatic logic [LEVEL_W-1:0] eff_level(input logic                full,
                                                   input logic [USEDW_W-1:0] usedw);
    return full ? LEVEL_FULL : {1'b0, usedw};
  endfunction

endpackage

// File: rtl/skid_buf_2.sv
// Two-entry in-order skid buffer; input ready depends only on occupancy.
module skid_buf_2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = head_q;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  // Occupancy and entry update; head is always the oldest word
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = in_data_i;
        else               tail_d = in_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // simultaneous push and pop: occupancy unchanged, order kept
        if (cnt_q == 2'd1) begin
          head_d = in_data_i;
        end else begin
          head_d = tail_q;
          tail_d = in_data_i;
        end
      end
      default: ;
    endcase
  end

  // Storage registers, cleared on reset so the output word reads zero
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_12b_sa_drain.sv
// Drains a 12-bit show-ahead FIFO in bursts on level threshold or timeout.
module fifo_12b_sa_drain
  import fifo_drain_pkg::*;
#(
  parameter int unsigned THRESH    = 32,
  parameter int unsigned TIMEOUT   = 256,
  parameter int unsigned MAX_BURST = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic [DATA_W-1:0]  fifo_q,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic               fifo_full,
  input  logic               fifo_empty,
  output logic               fifo_rdreq,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready,
  output logic [15:0]        pop_count,
  output logic               full_seen
);

  localparam logic [LEVEL_W-1:0] THRESH_L     = 8'(THRESH);
  localparam logic [15:0]        TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0]         BURST_MAX    = 8'(MAX_BURST);
  localparam logic [7:0]         BURST_LAST   = 8'(MAX_BURST - 1);

  drain_state_e       state_q, state_d;
  logic [15:0]        timer_q, timer_d;
  logic [7:0]         burst_q, burst_d;
  logic [15:0]        pop_cnt_q, pop_cnt_d;
  logic               full_seen_q, full_seen_d;
  logic [LEVEL_W-1:0] level;
  logic               skid_ready;

  assign level = eff_level(fifo_full, fifo_usedw);

  assign fifo_rdreq = (state_q == ST_DRAIN) & en & ~fifo_empty & skid_ready
                    & (burst_q < BURST_MAX);

  assign pop_count = pop_cnt_q;
  assign full_seen = full_seen_q;

  // Next state, wait timer and burst counter; timer/burst reset to zero by default
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    burst_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_GATHER;
      end
      ST_GATHER: begin
        if ((level >= THRESH_L) || (!fifo_empty && (timer_q == TIMEOUT_LAST))) begin
          state_d = ST_DRAIN;
        end else if (!fifo_empty) begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_DRAIN: begin
        if (fifo_rdreq) begin
          burst_d = burst_q + 8'd1;
          if (burst_q == BURST_LAST) state_d = ST_GATHER;
        end else if (fifo_empty) begin
          state_d = ST_GATHER;
        end else begin
          burst_d = burst_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!en) begin
      state_d = ST_IDLE;
      timer_d = '0;
      burst_d = '0;
    end
  end

  // Statistics: pop counter wraps naturally, full flag is sticky
  always_comb begin
    pop_cnt_d   = pop_cnt_q + 16'(fifo_rdreq);
    full_seen_d = full_seen_q | fifo_full;
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      burst_q     <= '0;
      pop_cnt_q   <= '0;
      full_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      burst_q     <= burst_d;
      pop_cnt_q   <= pop_cnt_d;
      full_seen_q <= full_seen_d;
    end
  end

  skid_buf_2 #(
    .WIDTH(DATA_W)
  ) u_skid (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .in_valid_i (fifo_rdreq),
    .in_ready_o (skid_ready),
    .in_data_i  (fifo_q),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data)
  );

endmodule

// File: tb/tb_fifo_12b_sa_drain.sv
// Self-checking bench: queue-based FIFO model, in-order stream scoreboard.
module tb_fifo_12b_sa_drain;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [11:0] fifo_q;
  logic [6:0]  fifo_usedw;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_rdreq;
  logic        out_valid;
  logic [11:0] out_data;
  logic        out_ready;
  logic [15:0] pop_count;
  logic        full_seen;

  fifo_12b_sa_drain #(
    .THRESH(32),
    .TIMEOUT(256),
    .MAX_BURST(64)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .fifo_q    (fifo_q),
    .fifo_usedw(fifo_usedw),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .fifo_rdreq(fifo_rdreq),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .pop_count (pop_count),
    .full_seen (full_seen)
  );

  always #5 clk = ~clk;

  logic [11:0] fq[$];
  logic [11:0] expq[$];
  logic [11:0] got[$];
  int unsigned npops  = 0;
  int unsigned pushed = 0;
  bit          pop_pend = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;

  // FIFO model outputs follow the queue (show-ahead head word)
  task automatic upd();
    fifo_empty <= (fq.size() == 0);
    fifo_full  <= (fq.size() == 128);
    fifo_usedw <= 7'(fq.size());
    fifo_q     <= (fq.size() == 0) ? 12'h000 : fq[0];
  endtask

  task automatic push_word();
    logic [11:0] d;
    if (fq.size() < 128) begin
      d = 12'($urandom);
      fq.push_back(d);
      expq.push_back(d);
      pushed++;
      upd();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int stream_bad();
    int bad = 0;
    if (got.size() != expq.size()) bad++;
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      if (got[i] !== expq[i]) bad++;
    return bad;
  endfunction

  task automatic clear_streams();
    expq.delete();
    got.delete();
  endtask

  task automatic drain_wait(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (fq.size() == 0 && !out_valid && !fifo_rdreq) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Monitor: sample pops and accepted words mid-cycle
  always @(negedge clk) begin
    pop_pend = 1'b0;
    if (reset_n) begin
      if (fifo_rdreq) begin
        pop_pend = 1'b1;
        npops++;
      end
      if (out_valid && out_ready) got.push_back(out_data);
    end
  end

  // FIFO model: head leaves on the edge that follows a sampled rdreq
  always @(posedge clk) begin
    if (reset_n && pop_pend && fq.size() > 0) begin
      void'(fq.pop_front());
      upd();
    end
  end

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; out_ready = 1'b0;
    fq.delete(); upd();
    repeat (3) step();
    n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_out_valid: actual %b required 0", out_valid); end
    n_checks++; if (out_data !== 12'h000) begin n_fail++; $display("FAIL reset_out_data: actual %h required 000", out_data); end
    n_checks++; if (fifo_rdreq !== 1'b0)  begin n_fail++; $display("FAIL reset_rdreq: actual %b required 0", fifo_rdreq); end
    n_checks++; if (pop_count !== 16'd0)  begin n_fail++; $display("FAIL reset_pop_count: actual %0d required 0", pop_count); end
    n_checks++; if (full_seen !== 1'b0)   begin n_fail++; $display("FAIL reset_full_seen: actual %b required 0", full_seen); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_threshold();
    int unsigned p0;
    bit ok;
    out_ready = 1'b1; en = 1'b1;
    repeat (3) step();
    p0 = npops;
    repeat (31) begin push_word(); step(); end
    n_checks++; if (npops - p0 !== 0) begin n_fail++; $display("FAIL thresh_31_no_pop: actual %0d pops required 0", npops - p0); end
    push_word();
    @(negedge clk);
    n_checks++; if (fifo_rdreq !== 1'b0) begin n_fail++; $display("FAIL thresh_32_same_cycle: actual %b required 0", fifo_rdreq); end
    step();
    n_checks++; if (fifo_rdreq !== 1'b1) begin n_fail++; $display("FAIL thresh_32_drain: actual %b required 1", fifo_rdreq); end
    drain_wait(200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL thresh_drain_timeout: actual stuck required drained"); end
    n_checks++; if (npops - p0 !== 32) begin n_fail++; $display("FAIL thresh_pops: actual %0d required 32", npops - p0); end
    n_checks++; if (stream_bad() !== 0) begin n_fail++; $display("FAIL thresh_order: actual %0d bad words required 0", stream_bad()); end
    n_checks++; if (pop_count !== 16'(pushed)) begin n_fail++; $display("FAIL thresh_pop_count: actual %0d required %0d", pop_count, pushed); end
    clear_streams();
  endtask

  task automatic test_timeout();
    int unsigned p0;
    int cyc = 0;
    bit found = 1'b0;
    bit ok;
    p0 = npops;
    push_word();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (fifo_rdreq) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL timeout_seen: actual no rdreq required rdreq"); end
    n_checks++; if (cyc !== 256) begin n_fail++; $display("FAIL timeout_cycles: actual %0d required 256", cyc); end
    drain_wait(50, ok);
    n_checks++; if (!ok || npops - p0 !== 1) begin n_fail++; $display("FAIL timeout_pops: actual %0d required 1", npops - p0); end
    n_checks++; if (stream_bad() !== 0) begin n_fail++; $display("FAIL timeout_order: actual %0d bad words required 0", stream_bad()); end
    clear_streams();
  endtask

  task automatic test_full_burst();
    int unsigned p0;
    int run = 0;
    bit found = 1'b0;
    bit ok;
    en = 1'b0; step();
    p0 = npops;
    repeat (128) begin push_word(); step(); end
    n_checks++; if (npops - p0 !== 0) begin n_fail++; $display("FAIL full_idle_pops: actual %0d required 0", npops - p0); end
    n_checks++; if (full_seen !== 1'b1) begin n_fail++; $display("FAIL full_seen_set: actual %b required 1", full_seen); end
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rdreq) begin found = 1'b1; break; end
    end
    for (int i = 0; i < 200; i++) begin
      if (!fifo_rdreq) break;
      run++;
      @(negedge clk);
    end
    n_checks++; if (!found || run !== 64) begin n_fail++; $display("FAIL full_burst_len: actual %0d required 64", run); end
    drain_wait(500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL full_drain_timeout: actual stuck required drained"); end
    n_checks++; if (stream_bad() !== 0) begin n_fail++; $display("FAIL full_order: actual %0d bad words required 0", stream_bad()); end
    n_checks++; if (full_seen !== 1'b1) begin n_fail++; $display("FAIL full_seen_sticky: actual %b required 1", full_seen); end
    n_checks++; if (pop_count !== 16'(pushed)) begin n_fail++; $display("FAIL full_pop_count: actual %0d required %0d", pop_count, pushed); end
    clear_streams();
  endtask

  task automatic test_backpressure();
    int unsigned p0;
    bit ok;
    en = 1'b0; step();
    out_ready = 1'b0;
    p0 = npops;
    repeat (40) begin push_word(); step(); end
    en = 1'b1;
    repeat (20) step();
    n_checks++; if (npops - p0 !== 2) begin n_fail++; $display("FAIL bp_pops: actual %0d required 2", npops - p0); end
    n_checks++; if (fifo_rdreq !== 1'b0) begin n_fail++; $display("FAIL bp_rdreq: actual %b required 0", fifo_rdreq); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== expq[0]) begin n_fail++; $display("FAIL bp_hold: actual %b/%h required 1/%h", out_valid, out_data, expq[0]); end
    out_ready = 1'b1;
    repeat (40) step();
    n_checks++; if (got.size() !== 40) begin n_fail++; $display("FAIL bp_back_to_back: actual %0d words required 40", got.size()); end
    drain_wait(50, ok);
    n_checks++; if (!ok || stream_bad() !== 0) begin n_fail++; $display("FAIL bp_order: actual %0d bad words required 0", stream_bad()); end
    clear_streams();
  endtask

  task automatic test_reset_midburst();
    int unsigned p0;
    en = 1'b0; step();
    repeat (60) begin push_word(); step(); end
    en = 1'b1; out_ready = 1'b1;
    p0 = npops;
    for (int i = 0; i < 20; i++) begin
      step();
      if (npops - p0 >= 3) break;
    end
    @(negedge clk);
    n_checks++; if (fifo_rdreq !== 1'b1) begin n_fail++; $display("FAIL rst_mid_active: actual %b required 1", fifo_rdreq); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_mid_out_valid: actual %b required 0", out_valid); end
    n_checks++; if (fifo_rdreq !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_rdreq: actual %b required 0", fifo_rdreq); end
    n_checks++; if (pop_count !== 16'd0)  begin n_fail++; $display("FAIL rst_mid_pop_count: actual %0d required 0", pop_count); end
    n_checks++; if (out_data !== 12'h000) begin n_fail++; $display("FAIL rst_mid_out_data: actual %h required 000", out_data); end
    n_checks++; if (full_seen !== 1'b0)   begin n_fail++; $display("FAIL rst_mid_full_seen: actual %b required 0", full_seen); end
    fq.delete(); upd();
    clear_streams();
    pushed = 0; npops = 0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    n_checks++; if (pop_count !== 16'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release: actual %0d/%b required 0/0", pop_count, out_valid); end
  endtask

  task automatic test_en_drop();
    int unsigned p0, p1;
    int bad = 0;
    bit ok;
    en = 1'b0; step();
    repeat (60) begin push_word(); step(); end
    en = 1'b1; out_ready = 1'b1;
    p0 = npops;
    for (int i = 0; i < 30; i++) begin
      step();
      if (npops - p0 >= 5) break;
    end
    en = 1'b0;
    p1 = npops;
    @(negedge clk);
    n_checks++; if (fifo_rdreq !== 1'b0) begin n_fail++; $display("FAIL en_drop_rdreq: actual %b required 0", fifo_rdreq); end
    repeat (10) step();
    n_checks++; if (npops !== p1) begin n_fail++; $display("FAIL en_drop_pops: actual %0d required %0d", npops, p1); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL en_drop_drained: actual %b required 0", out_valid); end
    for (int i = 0; i < got.size(); i++) if (got[i] !== expq[i]) bad++;
    n_checks++; if (got.size() !== int'(p1 - p0) || bad !== 0) begin n_fail++; $display("FAIL en_drop_words: actual %0d words %0d bad required %0d words 0 bad", got.size(), bad, p1 - p0); end
    en = 1'b1;
    drain_wait(500, ok);
    n_checks++; if (!ok || stream_bad() !== 0) begin n_fail++; $display("FAIL en_resume_order: actual %0d bad words required 0", stream_bad()); end
    n_checks++; if (pop_count !== 16'(pushed)) begin n_fail++; $display("FAIL en_pop_count: actual %0d required %0d", pop_count, pushed); end
    clear_streams();
  endtask

  task automatic test_random();
    bit          prev_stall = 1'b0;
    logic [11:0] prev_data  = 12'h000;
    bit ok;
    en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      step();
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          n_fail++; $display("FAIL rand_hold: actual %b/%h required 1/%h", out_valid, out_data, prev_data);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) push_word();
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
    out_ready = 1'b1;
    drain_wait(3000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_drain_timeout: actual stuck required drained"); end
    n_checks++; if (stream_bad() !== 0) begin n_fail++; $display("FAIL rand_order: actual %0d bad words required 0", stream_bad()); end
    n_checks++; if (pop_count !== 16'(pushed)) begin n_fail++; $display("FAIL rand_pop_count: actual %0d required %0d", pop_count, pushed); end
    clear_streams();
  endtask

  initial begin
    upd();
    test_reset();
    test_threshold();
    test_timeout();
    test_full_burst();
    test_backpressure();
    test_reset_midburst();
    test_en_drop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
